// File: rtl/axi_bram_responder.sv
// AXI4 slave backed by on-chip block RAM; one INCR burst at a time, used as the
// bring-up target for the USB-to-DDR3 command bridge.
`timescale 1ns/1ps
module axi_bram_responder #(
   parameter int WIDTH = 32,
   parameter int MASKS = WIDTH / 8,
   parameter int ADDRS = 27,
   parameter int REQID = 4,
   parameter int DBITS = 10
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             awvalid_i,
   output logic             awready_o,
   input  logic [1:0]       awburst_i,
   input  logic [7:0]       awlen_i,
   input  logic [REQID-1:0] awid_i,
   input  logic [ADDRS-1:0] awaddr_i,
   input  logic             wvalid_i,
   output logic             wready_o,
   input  logic             wlast_i,
   input  logic [MASKS-1:0] wstrb_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             bvalid_o,
   input  logic             bready_i,
   output logic [REQID-1:0] bid_o,
   output logic [1:0]       bresp_o,
   input  logic             arvalid_i,
   output logic             arready_o,
   input  logic [1:0]       arburst_i,
   input  logic [7:0]       arlen_i,
   input  logic [REQID-1:0] arid_i,
   input  logic [ADDRS-1:0] araddr_i,
   output logic             rvalid_o,
   input  logic             rready_i,
   output logic             rlast_o,
   output logic [REQID-1:0] rid_o,
   output logic [1:0]       rresp_o,
   output logic [WIDTH-1:0] rdata_o
);

   // state | meaning
   // IDLE  | waiting for AW or AR, round-robin on conflict
   // WDAT  | accepting write beats
   // BRSP  | holding write response until bready
   // RADR  | first RAM read issued
   // RDAT  | streaming read beats with one-word prefetch
   typedef enum logic [2:0] {IDLE, WDAT, BRSP, RADR, RDAT} state_t;

   state_t           state, state_nx;
   logic             en, last_wr, err;
   logic [REQID-1:0] id_q;
   logic [7:0]       len_q, cnt;
   logic [DBITS-1:0] ptr;
   logic [WIDTH-1:0] mem [2**DBITS];
   logic [WIDTH-1:0] rd_q;
   logic             aw_hs, ar_hs, w_hs, r_done, ld, re, we, is_len;
   logic             unused_addr;

   assign awready_o = (state == IDLE) & en & ~(arvalid_i & last_wr);
   assign arready_o = (state == IDLE) & en & ~(awvalid_i & ~last_wr);
   assign wready_o  = (state == WDAT);
   assign bvalid_o  = (state == BRSP);
   assign bid_o     = id_q;
   assign rid_o     = id_q;
   assign bresp_o   = err ? 2'b10 : 2'b00;
   assign rresp_o   = err ? 2'b10 : 2'b00;

   assign aw_hs  = awvalid_i & awready_o;
   assign ar_hs  = arvalid_i & arready_o;
   assign w_hs   = wvalid_i & wready_o;
   assign is_len = (cnt == len_q);
   // Load the output stage from the prefetch word; the last beat is never reloaded.
   assign ld     = (state == RDAT) & (~rvalid_o | (rready_i & ~rlast_o));
   assign r_done = rvalid_o & rready_i & rlast_o;
   assign re     = (state == RADR) | ld;
   assign we     = w_hs & ~err;

   assign unused_addr = ^{awaddr_i[ADDRS-1:DBITS+2], awaddr_i[1:0],
                          araddr_i[ADDRS-1:DBITS+2], araddr_i[1:0]};

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (aw_hs) state_nx = WDAT;
               else if (ar_hs) state_nx = RADR;
         WDAT: if (w_hs && wlast_i) state_nx = BRSP;
         BRSP: if (bready_i) state_nx = IDLE;
         RADR: state_nx = RDAT;
         RDAT: if (r_done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         en       <= 1'b0;
         last_wr  <= 1'b0;
         err      <= 1'b0;
         id_q     <= '0;
         len_q    <= '0;
         cnt      <= '0;
         ptr      <= '0;
         rvalid_o <= 1'b0;
         rlast_o  <= 1'b0;
         rdata_o  <= '0;
      end else begin
         state <= state_nx;
         en    <= (state_nx == IDLE);
         if (aw_hs) begin
            last_wr <= 1'b1;
            id_q    <= awid_i;
            len_q   <= awlen_i;
            ptr     <= awaddr_i[DBITS+1:2];
            err     <= (awburst_i != 2'b01);
            cnt     <= '0;
         end
         if (ar_hs) begin
            last_wr <= 1'b0;
            id_q    <= arid_i;
            len_q   <= arlen_i;
            ptr     <= araddr_i[DBITS+1:2];
            err     <= (arburst_i != 2'b01);
            cnt     <= '0;
         end
         if (w_hs) begin
            ptr <= ptr + DBITS'(1);
            cnt <= cnt + 8'd1;
            // wlast must coincide exactly with beat len; either mismatch poisons the burst
            if (wlast_i != is_len) err <= 1'b1;
         end
         if (re) ptr <= ptr + DBITS'(1);
         if (ld) begin
            rvalid_o <= 1'b1;
            rdata_o  <= rd_q;
            rlast_o  <= is_len;
            cnt      <= cnt + 8'd1;
         end else if (r_done) begin
            rvalid_o <= 1'b0;
            rlast_o  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (we) begin
         for (int i = 0; i < MASKS; i++) begin
            if (wstrb_i[i]) mem[ptr][i*8 +: 8] <= wdata_i[i*8 +: 8];
         end
      end
      if (re) rd_q <= mem[ptr];
   end

endmodule

// File: tb/tb_axi_bram_responder.sv
// Directed bench for axi_bram_responder: writes, reads, strobes, errors,
// arbitration, wrap-around and mid-burst reset.
`timescale 1ns/1ps
module tb_axi_bram_responder;

   logic        clock, reset_n;
   logic        awvalid_i, awready_o;
   logic [1:0]  awburst_i;
   logic [7:0]  awlen_i;
   logic [3:0]  awid_i;
   logic [26:0] awaddr_i;
   logic        wvalid_i, wready_o, wlast_i;
   logic [3:0]  wstrb_i;
   logic [31:0] wdata_i;
   logic        bvalid_o, bready_i;
   logic [3:0]  bid_o;
   logic [1:0]  bresp_o;
   logic        arvalid_i, arready_o;
   logic [1:0]  arburst_i;
   logic [7:0]  arlen_i;
   logic [3:0]  arid_i;
   logic [26:0] araddr_i;
   logic        rvalid_o, rready_i, rlast_o;
   logic [3:0]  rid_o;
   logic [1:0]  rresp_o;
   logic [31:0] rdata_o;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] wbuf   [16];
   logic [31:0] exp_rd [16];
   logic        other;

   axi_bram_responder dut (
      .clock(clock), .reset_n(reset_n),
      .awvalid_i(awvalid_i), .awready_o(awready_o), .awburst_i(awburst_i),
      .awlen_i(awlen_i), .awid_i(awid_i), .awaddr_i(awaddr_i),
      .wvalid_i(wvalid_i), .wready_o(wready_o), .wlast_i(wlast_i),
      .wstrb_i(wstrb_i), .wdata_i(wdata_i),
      .bvalid_o(bvalid_o), .bready_i(bready_i), .bid_o(bid_o), .bresp_o(bresp_o),
      .arvalid_i(arvalid_i), .arready_o(arready_o), .arburst_i(arburst_i),
      .arlen_i(arlen_i), .arid_i(arid_i), .araddr_i(araddr_i),
      .rvalid_o(rvalid_o), .rready_i(rready_i), .rlast_o(rlast_o),
      .rid_o(rid_o), .rresp_o(rresp_o), .rdata_o(rdata_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic aw_hs(input logic [26:0] a, input logic [7:0] l, input logic [1:0] b,
                        input logic [3:0] id, output logic ar_seen);
      int n = 0;
      awvalid_i = 1'b1; awaddr_i = a; awlen_i = l; awburst_i = b; awid_i = id;
      @(negedge clock);
      while (!awready_o && n < 200) begin @(negedge clock); n++; end
      chk("aw_ready", 32'(awready_o), 32'd1);
      ar_seen = arready_o;
      @(posedge clock); #1;
      awvalid_i = 1'b0;
   endtask

   task automatic ar_hs(input logic [26:0] a, input logic [7:0] l, input logic [1:0] b,
                        input logic [3:0] id, output logic aw_seen);
      int n = 0;
      arvalid_i = 1'b1; araddr_i = a; arlen_i = l; arburst_i = b; arid_i = id;
      @(negedge clock);
      while (!arready_o && n < 200) begin @(negedge clock); n++; end
      chk("ar_ready", 32'(arready_o), 32'd1);
      aw_seen = awready_o;
      @(posedge clock); #1;
      arvalid_i = 1'b0;
   endtask

   task automatic w_beats(input int n, input int lastidx, input logic [3:0] strb);
      for (int i = 0; i < n; i++) begin
         int k = 0;
         wvalid_i = 1'b1; wdata_i = wbuf[i]; wstrb_i = strb; wlast_i = (i == lastidx);
         @(negedge clock);
         while (!wready_o && k < 200) begin @(negedge clock); k++; end
         if (!wready_o) chk($sformatf("w_ready%0d", i), 32'(wready_o), 32'd1);
         @(posedge clock); #1;
      end
      wvalid_i = 1'b0; wlast_i = 1'b0;
   endtask

   task automatic b_resp(input string tag, input logic [1:0] eresp, input logic [3:0] eid);
      int k = 0;
      bready_i = 1'b1;
      @(negedge clock);
      while (!bvalid_o && k < 200) begin @(negedge clock); k++; end
      if (!bvalid_o) chk({tag, "_bvalid"}, 32'(bvalid_o), 32'd1);
      chk({tag, "_bresp"}, 32'(bresp_o), 32'(eresp));
      chk({tag, "_bid"}, 32'(bid_o), 32'(eid));
      @(posedge clock); #1;
      bready_i = 1'b0;
   endtask

   task automatic r_beats(input string tag, input int n, input bit toggle,
                          input logic [1:0] eresp, input logic [3:0] eid);
      int k = 0, got = 0, first = -1;
      logic stalled = 1'b0;
      logic [31:0] held = '0;
      while (got < n && k < 400) begin
         rready_i = toggle ? ((k % 2) == 0) : 1'b1;
         @(negedge clock); k++;
         if (rvalid_o && first < 0) first = k;
         if (stalled) chk($sformatf("%s_hold%0d", tag, got), rdata_o, held);
         stalled = 1'b0;
         if (rvalid_o && rready_i) begin
            chk($sformatf("%s_rdata%0d", tag, got), rdata_o, exp_rd[got]);
            chk($sformatf("%s_rlast%0d", tag, got), 32'(rlast_o), 32'(got == n - 1));
            chk($sformatf("%s_rresp%0d", tag, got), 32'(rresp_o), 32'(eresp));
            chk($sformatf("%s_rid%0d", tag, got), 32'(rid_o), 32'(eid));
            got++;
         end else if (rvalid_o) begin
            stalled = 1'b1;
            held = rdata_o;
         end
         @(posedge clock); #1;
      end
      rready_i = 1'b0;
      if (got < n) chk({tag, "_rcount"}, got, n);
      chk({tag, "_rlat"}, first, 32'd3);
      if (!toggle) chk({tag, "_b2b"}, k - first + 1, n);
   endtask

   initial begin
      reset_n = 1'b0;
      awvalid_i = 0; awburst_i = 0; awlen_i = 0; awid_i = 0; awaddr_i = 0;
      wvalid_i = 0; wlast_i = 0; wstrb_i = 0; wdata_i = 0; bready_i = 0;
      arvalid_i = 0; arburst_i = 0; arlen_i = 0; arid_i = 0; araddr_i = 0;
      rready_i = 0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_awready", 32'(awready_o), 32'd0);
      chk("rst_arready", 32'(arready_o), 32'd0);
      chk("rst_wready",  32'(wready_o),  32'd0);
      chk("rst_bvalid",  32'(bvalid_o),  32'd0);
      chk("rst_rvalid",  32'(rvalid_o),  32'd0);
      chk("rst_rlast",   32'(rlast_o),   32'd0);
      chk("rst_resp",    32'({bresp_o, rresp_o}), 32'd0);
      chk("rst_ids",     32'({bid_o, rid_o}), 32'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      awvalid_i = 1'b1; awburst_i = 2'b01;
      @(negedge clock);
      chk("en_delay", 32'(awready_o), 32'd0);
      awvalid_i = 1'b0;
      @(posedge clock); #1;

      // single beat write then read back
      wbuf[0] = 32'hDEADBEEF;
      aw_hs(27'h000010, 8'd0, 2'b01, 4'h3, other);
      w_beats(1, 0, 4'hF);
      b_resp("single", 2'b00, 4'h3);
      exp_rd[0] = 32'hDEADBEEF;
      ar_hs(27'h000010, 8'd0, 2'b01, 4'h5, other);
      r_beats("single", 1, 1'b0, 2'b00, 4'h5);

      // 16-beat burst, read with stalls and then back-to-back
      for (int i = 0; i < 16; i++) begin wbuf[i] = i; exp_rd[i] = i; end
      aw_hs(27'h000100, 8'd15, 2'b01, 4'h1, other);
      w_beats(16, 15, 4'hF);
      b_resp("burst", 2'b00, 4'h1);
      ar_hs(27'h000100, 8'd15, 2'b01, 4'h2, other);
      r_beats("burst_tog", 16, 1'b1, 2'b00, 4'h2);
      ar_hs(27'h000100, 8'd15, 2'b01, 4'h4, other);
      r_beats("burst_b2b", 16, 1'b0, 2'b00, 4'h4);

      // partial strobes
      wbuf[0] = 32'h11223344;
      aw_hs(27'h000200, 8'd0, 2'b01, 4'h0, other);
      w_beats(1, 0, 4'hF);
      b_resp("strb_a", 2'b00, 4'h0);
      wbuf[0] = 32'hAABBCCDD;
      aw_hs(27'h000200, 8'd0, 2'b01, 4'h0, other);
      w_beats(1, 0, 4'b0101);
      b_resp("strb_b", 2'b00, 4'h0);
      exp_rd[0] = 32'h11BB33DD;
      ar_hs(27'h000200, 8'd0, 2'b01, 4'h6, other);
      r_beats("strb", 1, 1'b0, 2'b00, 4'h6);

      // non-INCR bursts: write discarded, read returns data flagged SLVERR
      for (int i = 0; i < 4; i++) wbuf[i] = 32'hF0F0_0000 + i;
      aw_hs(27'h000100, 8'd3, 2'b00, 4'h7, other);
      w_beats(4, 3, 4'hF);
      b_resp("fixed", 2'b10, 4'h7);
      for (int i = 0; i < 4; i++) exp_rd[i] = i;
      ar_hs(27'h000100, 8'd3, 2'b01, 4'h8, other);
      r_beats("fixed_unch", 4, 1'b0, 2'b00, 4'h8);
      exp_rd[0] = 32'hDEADBEEF;
      ar_hs(27'h000010, 8'd0, 2'b10, 4'h9, other);
      r_beats("wrapburst", 1, 1'b0, 2'b10, 4'h9);

      // arbitration: first conflict goes to write, next one to read
      arvalid_i = 1'b1; araddr_i = 27'h000300; arlen_i = 0; arburst_i = 2'b01; arid_i = 4'hA;
      wbuf[0] = 32'hA5A5A5A5;
      aw_hs(27'h000300, 8'd0, 2'b01, 4'h6, other);
      chk("conf1_arready", 32'(other), 32'd0);
      awvalid_i = 1'b1; awaddr_i = 27'h000300; awlen_i = 0; awburst_i = 2'b01; awid_i = 4'hB;
      w_beats(1, 0, 4'hF);
      b_resp("conf1", 2'b00, 4'h6);
      ar_hs(27'h000300, 8'd0, 2'b01, 4'hA, other);
      chk("conf2_awready", 32'(other), 32'd0);
      exp_rd[0] = 32'hA5A5A5A5;
      r_beats("conf_rd", 1, 1'b0, 2'b00, 4'hA);
      wbuf[0] = 32'h12345678;
      aw_hs(27'h000300, 8'd0, 2'b01, 4'hB, other);
      w_beats(1, 0, 4'hF);
      b_resp("conf2", 2'b00, 4'hB);
      exp_rd[0] = 32'h12345678;
      ar_hs(27'h000300, 8'd0, 2'b01, 4'hC, other);
      r_beats("conf_chk", 1, 1'b0, 2'b00, 4'hC);

      // early wlast on beat 1 of a 4-beat burst
      wbuf[0] = 32'h1; wbuf[1] = 32'h2;
      aw_hs(27'h000400, 8'd3, 2'b01, 4'hD, other);
      w_beats(2, 1, 4'hF);
      b_resp("early", 2'b10, 4'hD);
      @(negedge clock);
      chk("early_idle_awready", 32'(awready_o), 32'd1);
      chk("early_idle_wready", 32'(wready_o), 32'd0);
      @(posedge clock); #1;

      // word address wraps from 2^DBITS-1 to 0
      wbuf[0] = 32'h0BADF00D; wbuf[1] = 32'hC0FFEE00;
      aw_hs(27'h000FFC, 8'd1, 2'b01, 4'h2, other);
      w_beats(2, 1, 4'hF);
      b_resp("wrap", 2'b00, 4'h2);
      exp_rd[0] = 32'hC0FFEE00;
      ar_hs(27'h000000, 8'd0, 2'b01, 4'h1, other);
      r_beats("wrap_w0", 1, 1'b0, 2'b00, 4'h1);
      exp_rd[0] = 32'h0BADF00D;
      ar_hs(27'h000FFC, 8'd0, 2'b01, 4'h1, other);
      r_beats("wrap_top", 1, 1'b0, 2'b00, 4'h1);
      exp_rd[0] = 32'hC0FFEE00;
      ar_hs(27'h001000, 8'd0, 2'b01, 4'h1, other);
      r_beats("wrap_hi", 1, 1'b0, 2'b00, 4'h1);

      // reset in the middle of a stalled read burst
      begin
         int k = 0;
         ar_hs(27'h000100, 8'd15, 2'b01, 4'h9, other);
         rready_i = 1'b0;
         @(negedge clock);
         while (!rvalid_o && k < 20) begin @(negedge clock); k++; end
         chk("rst_mid_pre", 32'(rvalid_o), 32'd1);
         @(posedge clock); #1;
         reset_n = 1'b0;
         #1;
         chk("rst_mid_rvalid", 32'(rvalid_o), 32'd0);
         chk("rst_mid_rlast", 32'(rlast_o), 32'd0);
         @(posedge clock); #1;
         reset_n = 1'b1;
      end
      exp_rd[0] = 32'hDEADBEEF;
      ar_hs(27'h000010, 8'd0, 2'b01, 4'h3, other);
      r_beats("post_rst", 1, 1'b0, 2'b00, 4'h3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
